// File: rtl/opl3_slot_sequencer.sv
// opl3_slot_sequencer: per-sample scheduler for the operator phase/waveform
// datapath. Issues every operator slot once per accepted sample tick, bank-major,
// and tracks in-flight slots through a tag delay line matching the datapath
// pipeline so that returning results can be labelled with their bank/op.
module opl3_slot_sequencer #(
  parameter int NUM_BANKS      = 2,
  parameter int OPS_PER_BANK   = 18,
  parameter int BANK_NUM_WIDTH = 1,
  parameter int OP_NUM_WIDTH   = 5,
  parameter int SLOT_SPACING   = 1,
  parameter int PIPE_LATENCY   = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sample_tick,
  input  logic                      enable,
  input  logic                      overrun_clr,
  output logic                      issue_en,
  output logic [BANK_NUM_WIDTH-1:0] bank_num,
  output logic [OP_NUM_WIDTH-1:0]   op_num,
  output logic                      first_slot,
  output logic                      last_slot,
  output logic                      busy,
  output logic                      ret_valid,
  output logic [BANK_NUM_WIDTH-1:0] ret_bank,
  output logic [OP_NUM_WIDTH-1:0]   ret_op,
  output logic                      sample_done,
  output logic                      overrun
);

  localparam int GW           = (SLOT_SPACING > 1) ? $clog2(SLOT_SPACING + 1) : 1;
  localparam int DW           = $clog2(PIPE_LATENCY + 1);
  localparam int GAP_LAST_INT = (SLOT_SPACING > 1) ? SLOT_SPACING - 2 : 0;

  localparam logic [BANK_NUM_WIDTH-1:0] BANK_LAST  = BANK_NUM_WIDTH'(NUM_BANKS - 1);
  localparam logic [OP_NUM_WIDTH-1:0]   OP_LAST    = OP_NUM_WIDTH'(OPS_PER_BANK - 1);
  localparam logic [GW-1:0]             GAP_LAST   = GW'(GAP_LAST_INT);
  localparam logic [DW-1:0]             DRAIN_LAST = DW'(PIPE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Tag travelling alongside a slot through the datapath pipeline.
  // Invalid tags carry zero bank/op so the return outputs read 0 when idle.
  typedef struct packed {
    logic                      valid;
    logic [BANK_NUM_WIDTH-1:0] bank;
    logic [OP_NUM_WIDTH-1:0]   op;
    logic                      done;
  } tag_t;

  state_e                    state_q, state_d;
  logic [BANK_NUM_WIDTH-1:0] cnt_bank_q, cnt_bank_d;
  logic [OP_NUM_WIDTH-1:0]   cnt_op_q, cnt_op_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic [DW-1:0]             drain_q, drain_d;
  logic                      issue_d;
  logic                      cnt_is_first;
  logic                      cnt_is_last;

  logic                      issue_q;
  logic [BANK_NUM_WIDTH-1:0] bank_q;
  logic [OP_NUM_WIDTH-1:0]   op_q;
  logic                      first_q;
  logic                      last_q;
  logic                      busy_q;
  logic                      overrun_q, overrun_d;

  tag_t                      tag_in;
  tag_t                      pipe_q [PIPE_LATENCY];

  // Next-state logic: walk IDLE -> (ISSUE [GAP])* -> DRAIN -> IDLE, and advance
  // the slot counter (which always names the next slot to issue) on every issue.
  always_comb begin
    state_d    = state_q;
    cnt_bank_d = cnt_bank_q;
    cnt_op_d   = cnt_op_q;
    gap_d      = gap_q;
    drain_d    = drain_q;

    case (state_q)
      IDLE: begin
        cnt_bank_d = '0;
        cnt_op_d   = '0;
        if (sample_tick && enable) state_d = ISSUE;
      end
      ISSUE: begin
        if (last_q) begin
          state_d = DRAIN;
          drain_d = '0;
        end else if (SLOT_SPACING > 1) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = ISSUE;
        else                   gap_d   = gap_q + GW'(1);
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = IDLE;
        else                       drain_d = drain_q + DW'(1);
      end
      default: state_d = IDLE;
    endcase

    issue_d      = (state_d == ISSUE);
    cnt_is_first = (cnt_bank_q == '0) && (cnt_op_q == '0);
    cnt_is_last  = (cnt_bank_q == BANK_LAST) && (cnt_op_q == OP_LAST);

    if (issue_d) begin
      if (cnt_op_q == OP_LAST) begin
        cnt_op_d   = '0;
        cnt_bank_d = (cnt_bank_q == BANK_LAST) ? '0 : cnt_bank_q + BANK_NUM_WIDTH'(1);
      end else begin
        cnt_op_d   = cnt_op_q + OP_NUM_WIDTH'(1);
      end
    end

    overrun_d = (sample_tick && busy_q) || (overrun_q && !overrun_clr);
  end

  // FSM state and slot/gap/drain counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_bank_q <= '0;
      cnt_op_q   <= '0;
      gap_q      <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_bank_q <= cnt_bank_d;
      cnt_op_q   <= cnt_op_d;
      gap_q      <= gap_d;
      drain_q    <= drain_d;
    end
  end

  // Registered issue-side outputs; bank/op keep the last issued slot during gaps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_q   <= 1'b0;
      bank_q    <= '0;
      op_q      <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      issue_q   <= issue_d;
      first_q   <= issue_d && cnt_is_first;
      last_q    <= issue_d && cnt_is_last;
      busy_q    <= (state_d != IDLE);
      overrun_q <= overrun_d;
      if (issue_d) begin
        bank_q <= cnt_bank_q;
        op_q   <= cnt_op_q;
      end
    end
  end

  always_comb begin
    tag_in.valid = issue_q;
    tag_in.bank  = issue_q ? bank_q : '0;
    tag_in.op    = issue_q ? op_q : '0;
    tag_in.done  = issue_q && last_q;
  end

  // Tag delay line: the slot issued PIPE_LATENCY cycles ago appears at the tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < PIPE_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign issue_en    = issue_q;
  assign bank_num    = bank_q;
  assign op_num      = op_q;
  assign first_slot  = first_q;
  assign last_slot   = last_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign ret_valid   = pipe_q[PIPE_LATENCY-1].valid;
  assign ret_bank    = pipe_q[PIPE_LATENCY-1].bank;
  assign ret_op      = pipe_q[PIPE_LATENCY-1].op;
  assign sample_done = pipe_q[PIPE_LATENCY-1].done;

endmodule

// File: tb/tb_opl3_slot_sequencer.sv
// tb_opl3_slot_sequencer: scoreboard bench. Instance 0 uses default parameters,
// instance 1 uses a slot spacing of 3. Every accepted tick pushes the expected
// issue, return and sample_done events; a negedge monitor pops and compares them.
module tb_opl3_slot_sequencer;

  localparam int BW  = 1;
  localparam int OW  = 5;
  localparam int NB  = 2;
  localparam int OPB = 18;
  localparam int N   = NB * OPB;
  localparam int PL  = 6;

  typedef struct {
    int cyc;
    int bank;
    int op;
    int first;
    int last;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sampleTick  [2];
  logic          enable      [2];
  logic          overrunClr  [2];
  logic          issueEn     [2];
  logic [BW-1:0] bankNum     [2];
  logic [OW-1:0] opNum       [2];
  logic          firstSlot   [2];
  logic          lastSlot    [2];
  logic          busy        [2];
  logic          retValid    [2];
  logic [BW-1:0] retBank     [2];
  logic [OW-1:0] retOp       [2];
  logic          sampleDone  [2];
  logic          overrun     [2];

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cyc         = 0;
  int   base        = 0;
  bit   monOn       = 1'b0;

  int   spacing  [2] = '{1, 3};
  ev_t  issQ     [2][$];
  ev_t  retQ     [2][$];
  int   doneQ    [2][$];
  int   busyFrom [2];
  int   busyTo   [2];
  int   ovExp    [2];
  int   ovPend   [2];
  int   heldBank [2];
  int   heldOp   [2];

  opl3_slot_sequencer #(
    .NUM_BANKS(NB), .OPS_PER_BANK(OPB), .BANK_NUM_WIDTH(BW), .OP_NUM_WIDTH(OW),
    .SLOT_SPACING(1), .PIPE_LATENCY(PL)
  ) dutA (
    .clk(clk), .reset_n(reset_n), .sample_tick(sampleTick[0]), .enable(enable[0]),
    .overrun_clr(overrunClr[0]), .issue_en(issueEn[0]), .bank_num(bankNum[0]),
    .op_num(opNum[0]), .first_slot(firstSlot[0]), .last_slot(lastSlot[0]),
    .busy(busy[0]), .ret_valid(retValid[0]), .ret_bank(retBank[0]), .ret_op(retOp[0]),
    .sample_done(sampleDone[0]), .overrun(overrun[0])
  );

  opl3_slot_sequencer #(
    .NUM_BANKS(NB), .OPS_PER_BANK(OPB), .BANK_NUM_WIDTH(BW), .OP_NUM_WIDTH(OW),
    .SLOT_SPACING(3), .PIPE_LATENCY(PL)
  ) dutB (
    .clk(clk), .reset_n(reset_n), .sample_tick(sampleTick[1]), .enable(enable[1]),
    .overrun_clr(overrunClr[1]), .issue_en(issueEn[1]), .bank_num(bankNum[1]),
    .op_num(opNum[1]), .first_slot(firstSlot[1]), .last_slot(lastSlot[1]),
    .busy(busy[1]), .ret_valid(retValid[1]), .ret_bank(retBank[1]), .ret_op(retOp[1]),
    .sample_done(sampleDone[1]), .overrun(overrun[1])
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input int obs, input int exp);
    testsRun++;
    if (obs != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc - base);
    end
  endtask

  // Clear the reference model to its post-reset state.
  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      issQ[i].delete();
      retQ[i].delete();
      doneQ[i].delete();
      busyFrom[i] = 1;
      busyTo[i]   = 0;
      ovExp[i]    = 0;
      ovPend[i]   = 0;
      heldBank[i] = 0;
      heldOp[i]   = 0;
    end
  endtask

  // Advance one clock; the cycle counter is owned by this task alone.
  task automatic nextCycle();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) ovExp[i] = ovPend[i];
    #1;
    for (int i = 0; i < 2; i++) begin
      sampleTick[i] = 1'b0;
      overrunClr[i] = 1'b0;
    end
  endtask

  task automatic waitRel(input int n);
    while (cyc < base + n) nextCycle();
  endtask

  // Drive one cycle of inputs on an instance and push what the design should do.
  task automatic applyStimulus(input int i, input bit tk, input bit en, input bit clr);
    bit busyNow;
    int t;
    int ic;
    ev_t e;
    t             = cyc;
    sampleTick[i] = tk;
    enable[i]     = en;
    overrunClr[i] = clr;
    busyNow       = (t >= busyFrom[i]) && (t <= busyTo[i]);
    if (tk && busyNow)  ovPend[i] = 1;
    else if (clr)       ovPend[i] = 0;
    if (tk && en && !busyNow) begin
      for (int k = 0; k < N; k++) begin
        ic      = t + 1 + k * spacing[i];
        e.cyc   = ic;
        e.bank  = k / OPB;
        e.op    = k % OPB;
        e.first = (k == 0) ? 1 : 0;
        e.last  = (k == N - 1) ? 1 : 0;
        issQ[i].push_back(e);
        e.cyc   = ic + PL;
        retQ[i].push_back(e);
      end
      doneQ[i].push_back(t + 1 + (N - 1) * spacing[i] + PL);
      busyFrom[i] = t + 1;
      busyTo[i]   = t + 1 + (N - 1) * spacing[i] + PL;
    end
  endtask

  task automatic checkAllZero(input int i);
    checkOutput($sformatf("rst%0d.issue_en", i), issueEn[i], 0);
    checkOutput($sformatf("rst%0d.bank_num", i), bankNum[i], 0);
    checkOutput($sformatf("rst%0d.op_num", i), opNum[i], 0);
    checkOutput($sformatf("rst%0d.first_slot", i), firstSlot[i], 0);
    checkOutput($sformatf("rst%0d.last_slot", i), lastSlot[i], 0);
    checkOutput($sformatf("rst%0d.busy", i), busy[i], 0);
    checkOutput($sformatf("rst%0d.ret_valid", i), retValid[i], 0);
    checkOutput($sformatf("rst%0d.ret_bank", i), retBank[i], 0);
    checkOutput($sformatf("rst%0d.ret_op", i), retOp[i], 0);
    checkOutput($sformatf("rst%0d.sample_done", i), sampleDone[i], 0);
    checkOutput($sformatf("rst%0d.overrun", i), overrun[i], 0);
  endtask

  // Per-cycle compare of one instance against the scoreboard queues.
  task automatic monitorInst(input int i);
    int  expIss;
    int  expRet;
    int  expDone;
    int  expBusy;
    ev_t e;
    expIss = (issQ[i].size() > 0 && issQ[i][0].cyc == cyc) ? 1 : 0;
    checkOutput($sformatf("u%0d.issue_en", i), issueEn[i], expIss);
    if (expIss == 1) begin
      e = issQ[i].pop_front();
      checkOutput($sformatf("u%0d.bank_num", i), bankNum[i], e.bank);
      checkOutput($sformatf("u%0d.op_num", i), opNum[i], e.op);
      checkOutput($sformatf("u%0d.first_slot", i), firstSlot[i], e.first);
      checkOutput($sformatf("u%0d.last_slot", i), lastSlot[i], e.last);
      heldBank[i] = e.bank;
      heldOp[i]   = e.op;
    end else begin
      checkOutput($sformatf("u%0d.bank_hold", i), bankNum[i], heldBank[i]);
      checkOutput($sformatf("u%0d.op_hold", i), opNum[i], heldOp[i]);
    end
    while (issQ[i].size() > 0 && issQ[i][0].cyc <= cyc) void'(issQ[i].pop_front());

    expRet = (retQ[i].size() > 0 && retQ[i][0].cyc == cyc) ? 1 : 0;
    checkOutput($sformatf("u%0d.ret_valid", i), retValid[i], expRet);
    if (expRet == 1) begin
      e = retQ[i].pop_front();
      checkOutput($sformatf("u%0d.ret_bank", i), retBank[i], e.bank);
      checkOutput($sformatf("u%0d.ret_op", i), retOp[i], e.op);
    end else begin
      checkOutput($sformatf("u%0d.ret_bank_idle", i), retBank[i], 0);
      checkOutput($sformatf("u%0d.ret_op_idle", i), retOp[i], 0);
    end
    while (retQ[i].size() > 0 && retQ[i][0].cyc <= cyc) void'(retQ[i].pop_front());

    expDone = (doneQ[i].size() > 0 && doneQ[i][0] == cyc) ? 1 : 0;
    checkOutput($sformatf("u%0d.sample_done", i), sampleDone[i], expDone);
    while (doneQ[i].size() > 0 && doneQ[i][0] <= cyc) void'(doneQ[i].pop_front());

    expBusy = (cyc >= busyFrom[i] && cyc <= busyTo[i]) ? 1 : 0;
    checkOutput($sformatf("u%0d.busy", i), busy[i], expBusy);
    checkOutput($sformatf("u%0d.overrun", i), overrun[i], ovExp[i]);
  endtask

  // Sample both instances mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (monOn) begin
      for (int i = 0; i < 2; i++) monitorInst(i);
    end
  end

  // Scenario sequencer: cycle numbers below are relative to the last reset release.
  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sampleTick[i] = 1'b0;
      enable[i]     = 1'b0;
      overrunClr[i] = 1'b0;
    end
    resetModel();
    monOn = 1'b1;
    nextCycle();
    nextCycle();
    checkAllZero(0);
    checkAllZero(1);
    reset_n = 1'b1;
    base    = cyc;

    waitRel(10);  applyStimulus(0, 1, 1, 0); applyStimulus(1, 1, 1, 0);
    waitRel(30);  applyStimulus(0, 1, 1, 0);
    waitRel(50);  applyStimulus(1, 1, 1, 0);
    waitRel(52);  applyStimulus(0, 1, 1, 0);
    waitRel(60);  applyStimulus(0, 0, 1, 1);
    waitRel(62);  applyStimulus(0, 1, 1, 0);
    waitRel(70);  applyStimulus(0, 1, 1, 1);
    waitRel(110); applyStimulus(0, 0, 1, 1);
    waitRel(130); applyStimulus(0, 1, 0, 0); applyStimulus(1, 0, 1, 1);
    waitRel(135); applyStimulus(0, 1, 1, 0);
    waitRel(145); applyStimulus(0, 0, 0, 0);
    waitRel(200); applyStimulus(0, 1, 1, 0);
    waitRel(243); applyStimulus(0, 1, 1, 0);
    waitRel(300); applyStimulus(0, 1, 1, 0);

    waitRel(311);
    reset_n = 1'b0;
    resetModel();
    #1;
    checkAllZero(0);
    checkAllZero(1);
    nextCycle();
    nextCycle();
    reset_n = 1'b1;
    base    = cyc;

    waitRel(5);   applyStimulus(0, 1, 1, 0);
    waitRel(60);

    checkOutput("issQ_left", issQ[0].size() + issQ[1].size(), 0);
    checkOutput("retQ_left", retQ[0].size() + retQ[1].size(), 0);
    checkOutput("doneQ_left", doneQ[0].size() + doneQ[1].size(), 0);

    monOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
